// File: rtl/lcd_pkg.sv
// Shared constants for the ST7789-style LCD bus: command codes and decoder states.
package lcd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_SLPIN   = 8'h10;
    localparam logic [BYTE_W-1:0] CMD_SLPOUT  = 8'h11;
    localparam logic [BYTE_W-1:0] CMD_INVOFF  = 8'h20;
    localparam logic [BYTE_W-1:0] CMD_INVON   = 8'h21;
    localparam logic [BYTE_W-1:0] CMD_DISPOFF = 8'h28;
    localparam logic [BYTE_W-1:0] CMD_DISPON  = 8'h29;
    localparam logic [BYTE_W-1:0] CMD_CASET   = 8'h2A;
    localparam logic [BYTE_W-1:0] CMD_RASET   = 8'h2B;
    localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_RASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } dec_state_t;

endpackage

// File: rtl/lcd_spi_monitor_if.sv
// 4-wire LCD serial bus as driven by the panel driver.
interface lcd_spi_monitor_if;
    logic lcd_clk;
    logic lcd_cs;
    logic lcd_rs;
    logic lcd_data;

    modport master (output lcd_clk, lcd_cs, lcd_rs, lcd_data);
    modport slave  (input  lcd_clk, lcd_cs, lcd_rs, lcd_data);
endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Synchronises the LCD pins, detects serial clock rising edges and assembles bytes.
module lcd_spi_byte_rx
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lcd_clk,
    input  logic              lcd_cs,
    input  logic              lcd_rs,
    input  logic              lcd_data,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_is_data,
    output logic              frame_err
);

    localparam int unsigned CNT_W = 3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_dly;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BYTE_W-2:0]      shift;
    logic                   clk_rise_c;

    assign clk_rise_c = clk_sync[SYNC_STAGES-1] & ~clk_dly;

    // Pin synchronisers; clk/cs reset high so no phantom edge or selection follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            cs_sync   <= '1;
            rs_sync   <= '0;
            data_sync <= '0;
            clk_dly   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], lcd_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
            clk_dly   <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Shift register and bit counter; deselect drops a partial byte and flags it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            shift        <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_sync[SYNC_STAGES-1]) begin
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (clk_rise_c) begin
                if (bit_cnt == CNT_W'(7)) begin
                    byte_data    <= {shift, data_sync[SYNC_STAGES-1]};
                    byte_is_data <= rs_sync[SYNC_STAGES-1];
                    byte_valid   <= 1'b1;
                    bit_cnt      <= '0;
                end else begin
                    shift   <= {shift[BYTE_W-3:0], data_sync[SYNC_STAGES-1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_monitor.sv
// LCD bus monitor: decodes commands, window setup and the RAMWR pixel stream.
module lcd_spi_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COORD_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    lcd_spi_monitor_if.slave   lcd,
    output logic               byte_valid,
    output logic [BYTE_W-1:0]  byte_data,
    output logic               byte_is_data,
    output logic               cmd_valid,
    output logic [BYTE_W-1:0]  cmd_code,
    output logic               pix_valid,
    output logic [PIX_W-1:0]   pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               sleep_out,
    output logic               disp_on,
    output logic               inv_on,
    output logic               frame_err
);

    localparam int unsigned IDX_W = 3;

    dec_state_t         state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [BYTE_W-1:0]  p0, p0_n, p1, p1_n, p2, p2_n, hi, hi_n;
    logic               half, half_n, adv, adv_n;
    logic [COORD_W-1:0] xs, xs_n, xe, xe_n, ys, ys_n, ye, ye_n;
    logic [COORD_W-1:0] x_n, y_n;
    logic               cmd_valid_n, pix_valid_n;
    logic [BYTE_W-1:0]  cmd_code_n;
    logic [PIX_W-1:0]   pix_data_n;
    logic               sleep_n, disp_n, inv_n;

    lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .lcd_clk      (lcd.lcd_clk),
        .lcd_cs       (lcd.lcd_cs),
        .lcd_rs       (lcd.lcd_rs),
        .lcd_data     (lcd.lcd_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .frame_err    (frame_err)
    );

    // Decoder state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            hi        <= '0;
            half      <= 1'b0;
            adv       <= 1'b0;
            xs        <= '0;
            xe        <= '1;
            ys        <= '0;
            ye        <= '1;
            pix_x     <= '0;
            pix_y     <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            sleep_out <= 1'b0;
            disp_on   <= 1'b0;
            inv_on    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            p0        <= p0_n;
            p1        <= p1_n;
            p2        <= p2_n;
            hi        <= hi_n;
            half      <= half_n;
            adv       <= adv_n;
            xs        <= xs_n;
            xe        <= xe_n;
            ys        <= ys_n;
            ye        <= ye_n;
            pix_x     <= x_n;
            pix_y     <= y_n;
            cmd_valid <= cmd_valid_n;
            cmd_code  <= cmd_code_n;
            pix_valid <= pix_valid_n;
            pix_data  <= pix_data_n;
            sleep_out <= sleep_n;
            disp_on   <= disp_n;
            inv_on    <= inv_n;
        end
    end

    // Next-state: command dispatch, window parameter capture, pixel assembly and walk.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        p0_n        = p0;
        p1_n        = p1;
        p2_n        = p2;
        hi_n        = hi;
        half_n      = half;
        adv_n       = 1'b0;
        xs_n        = xs;
        xe_n        = xe;
        ys_n        = ys;
        ye_n        = ye;
        x_n         = pix_x;
        y_n         = pix_y;
        cmd_valid_n = 1'b0;
        cmd_code_n  = cmd_code;
        pix_valid_n = 1'b0;
        pix_data_n  = pix_data;
        sleep_n     = sleep_out;
        disp_n      = disp_on;
        inv_n       = inv_on;

        // Coordinates move the cycle after a pixel is reported, inclusive window end.
        if (adv) begin
            if (pix_x == xe) begin
                x_n = xs;
                y_n = (pix_y == ye) ? ys : pix_y + COORD_W'(1);
            end else begin
                x_n = pix_x + COORD_W'(1);
            end
        end

        if (byte_valid) begin
            if (!byte_is_data) begin
                cmd_valid_n = 1'b1;
                cmd_code_n  = byte_data;
                idx_n       = '0;
                case (byte_data)
                    CMD_CASET:   state_n = ST_CASET;
                    CMD_RASET:   state_n = ST_RASET;
                    CMD_RAMWR: begin
                        state_n = ST_RAMWR;
                        x_n     = xs;
                        y_n     = ys;
                        half_n  = 1'b0;
                    end
                    CMD_SLPIN:   begin sleep_n = 1'b0; state_n = ST_IDLE; end
                    CMD_SLPOUT:  begin sleep_n = 1'b1; state_n = ST_IDLE; end
                    CMD_INVOFF:  begin inv_n   = 1'b0; state_n = ST_IDLE; end
                    CMD_INVON:   begin inv_n   = 1'b1; state_n = ST_IDLE; end
                    CMD_DISPOFF: begin disp_n  = 1'b0; state_n = ST_IDLE; end
                    CMD_DISPON:  begin disp_n  = 1'b1; state_n = ST_IDLE; end
                    default:     state_n = ST_SKIP;
                endcase
            end else begin
                case (state)
                    ST_CASET, ST_RASET: begin
                        case (idx)
                            IDX_W'(0): p0_n = byte_data;
                            IDX_W'(1): p1_n = byte_data;
                            IDX_W'(2): p2_n = byte_data;
                            IDX_W'(3): begin
                                if (state == ST_CASET) begin
                                    xs_n = COORD_W'({p0, p1});
                                    xe_n = COORD_W'({p2, byte_data});
                                end else begin
                                    ys_n = COORD_W'({p0, p1});
                                    ye_n = COORD_W'({p2, byte_data});
                                end
                            end
                            default: ;
                        endcase
                        if (idx != IDX_W'(4)) begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                    ST_RAMWR: begin
                        if (!half) begin
                            hi_n   = byte_data;
                            half_n = 1'b1;
                        end else begin
                            half_n      = 1'b0;
                            pix_valid_n = 1'b1;
                            pix_data_n  = {hi, byte_data};
                            adv_n       = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Bench for lcd_spi_monitor: directed scenarios plus randomized command streams
// checked against a byte-level model of the panel protocol.
module tb_lcd_spi_monitor;
    import lcd_pkg::*;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned COORD_W     = 9;
    localparam int          CMASK       = (1 << COORD_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               byte_valid, byte_is_data, cmd_valid, pix_valid;
    logic [7:0]         byte_data, cmd_code;
    logic [15:0]        pix_data;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic               sleep_out, disp_on, inv_on, frame_err;

    lcd_spi_monitor_if lcd ();

    lcd_spi_monitor #(.SYNC_STAGES(SYNC_STAGES), .COORD_W(COORD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd          (lcd),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .sleep_out    (sleep_out),
        .disp_on      (disp_on),
        .inv_on       (inv_on),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Free-running cycle counter and output monitor (observed on the falling edge).
    int          cyc = 0;
    int          got_bytes = 0;
    int          byte_cyc = 0;
    int          cmd_cyc = 0;
    logic [7:0]  last_byte = 8'h00;
    logic        last_is_data = 1'b0;
    logic [7:0]  got_cmd[$];
    logic [63:0] got_pix[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            got_bytes++;
            last_byte    = byte_data;
            last_is_data = byte_is_data;
            byte_cyc     = cyc;
        end
        if (cmd_valid) begin
            got_cmd.push_back(cmd_code);
            cmd_cyc = cyc;
        end
        if (pix_valid) begin
            got_pix.push_back((64'(pix_data) << 32) | (64'(pix_x) << 16) | 64'(pix_y));
        end
    end

    // Protocol model: remembers the last command and the data bytes that followed it.
    int          m_xs, m_xe, m_ys, m_ye;
    logic [7:0]  m_cmd;
    logic [7:0]  m_par[$];
    logic        m_sleep, m_disp, m_inv, m_ferr;
    int          exp_bytes = 0;
    logic [7:0]  exp_cmd[$];
    logic [63:0] exp_pix[$];
    int          cmd_chk = 0;
    int          pix_chk = 0;
    int          rise_cyc = 0;

    task automatic model_reset();
        m_xs = 0; m_xe = CMASK; m_ys = 0; m_ye = CMASK;
        m_cmd = 8'h00;
        m_par.delete();
        m_sleep = 1'b0; m_disp = 1'b0; m_inv = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_byte(input bit rs, input logic [7:0] b);
        int s, e, n, w, h, x, y, sz;
        logic [15:0] d;
        exp_bytes++;
        if (!rs) begin
            exp_cmd.push_back(b);
            m_cmd = b;
            m_par.delete();
            case (b)
                8'h10: m_sleep = 1'b0;
                8'h11: m_sleep = 1'b1;
                8'h20: m_inv   = 1'b0;
                8'h21: m_inv   = 1'b1;
                8'h28: m_disp  = 1'b0;
                8'h29: m_disp  = 1'b1;
                default: ;
            endcase
        end else begin
            m_par.push_back(b);
            sz = m_par.size();
            if ((m_cmd == 8'h2A || m_cmd == 8'h2B) && sz == 4) begin
                s = ((int'(m_par[0]) << 8) | int'(m_par[1])) & CMASK;
                e = ((int'(m_par[2]) << 8) | int'(m_par[3])) & CMASK;
                if (m_cmd == 8'h2A) begin m_xs = s; m_xe = e; end
                else                begin m_ys = s; m_ye = e; end
            end
            if (m_cmd == 8'h2C && (sz % 2) == 0) begin
                n = sz / 2 - 1;
                w = m_xe - m_xs + 1;
                h = m_ye - m_ys + 1;
                x = m_xs + n % w;
                y = m_ys + (n / w) % h;
                d = {m_par[sz-2], m_par[sz-1]};
                exp_pix.push_back((64'(d) << 32) | (64'(x) << 16) | 64'(y));
            end
        end
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b, input int half);
        lcd.lcd_rs = rs;
        for (int i = 7; i >= 0; i--) begin
            lcd.lcd_data = b[i];
            repeat (half) @(negedge clk);
            lcd.lcd_clk = 1'b1;
            rise_cyc = cyc;
            repeat (half) @(negedge clk);
            lcd.lcd_clk = 1'b0;
        end
        model_byte(rs, b);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(1'b0, b, int'($urandom_range(6, 3)));
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(1'b1, b, int'($urandom_range(6, 3)));
    endtask

    task automatic cs_low();
        lcd.lcd_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        lcd.lcd_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        repeat (12) @(negedge clk);
        check({tag, "_nbytes"}, 64'(got_bytes), 64'(exp_bytes));
        check({tag, "_ncmd"}, 64'(got_cmd.size()), 64'(exp_cmd.size()));
        check({tag, "_npix"}, 64'(got_pix.size()), 64'(exp_pix.size()));
        while (cmd_chk < exp_cmd.size() && cmd_chk < got_cmd.size()) begin
            check({tag, "_cmd"}, 64'(got_cmd[cmd_chk]), 64'(exp_cmd[cmd_chk]));
            cmd_chk++;
        end
        while (pix_chk < exp_pix.size() && pix_chk < got_pix.size()) begin
            check({tag, "_pix"}, got_pix[pix_chk], exp_pix[pix_chk]);
            pix_chk++;
        end
        cmd_chk = exp_cmd.size();
        pix_chk = exp_pix.size();
        check({tag, "_flags"}, 64'({sleep_out, disp_on, inv_on, frame_err}),
              64'({m_sleep, m_disp, m_inv, m_ferr}));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pulses"}, 64'({byte_valid, cmd_valid, pix_valid}), 64'(0));
        check({tag, "_bytes"}, 64'({byte_data, cmd_code}), 64'(0));
        check({tag, "_pix"}, 64'({pix_data, pix_x, pix_y}), 64'(0));
        check({tag, "_flags"}, 64'({sleep_out, disp_on, inv_on, frame_err}), 64'(0));
    endtask

    initial begin
        int k, s, e;
        logic [7:0] c;

        lcd.lcd_cs   = 1'b1;
        lcd.lcd_clk  = 1'b0;
        lcd.lcd_rs   = 1'b0;
        lcd.lcd_data = 1'b0;
        reset        = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("rst");

        // Single command at clk/8 with latency measurement.
        cs_low();
        send_byte(1'b0, 8'h11, 4);
        repeat (8) @(negedge clk);
        check("lat_byte", 64'(byte_cyc - rise_cyc), 64'(SYNC_STAGES + 1));
        check("lat_cmd", 64'(cmd_cyc - rise_cyc), 64'(SYNC_STAGES + 2));
        check("slpout_byte", 64'({last_byte, last_is_data}), 64'({8'h11, 1'b0}));
        compare_all("slpout");

        // Window setup then two pixels.
        cmd(8'h2A); dat(8'h00); dat(8'h28); dat(8'h01); dat(8'h17);
        cmd(8'h2B); dat(8'h00); dat(8'h35); dat(8'h00); dat(8'hBB);
        cmd(8'h2C); dat(8'h07); dat(8'hE0); dat(8'h00); dat(8'h1F);
        compare_all("win2");
        check("win2_p0", got_pix[got_pix.size()-2], (64'h07E0 << 32) | (64'd40 << 16) | 64'd53);
        check("win2_p1", got_pix[got_pix.size()-1], (64'h001F << 32) | (64'd41 << 16) | 64'd53);

        // Single-column window, wraps in both directions.
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h05);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h2C);
        for (int i = 0; i < 6; i++) begin
            dat(8'(i)); dat(8'($urandom));
        end
        compare_all("wrap");
        cs_high();

        // Partial byte on deselect, then a clean command.
        cs_low();
        lcd.lcd_rs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lcd.lcd_data = 1'b1;
            repeat (4) @(negedge clk);
            lcd.lcd_clk = 1'b1;
            repeat (4) @(negedge clk);
            lcd.lcd_clk = 1'b0;
        end
        cs_high();
        m_ferr = 1'b1;
        cs_low();
        cmd(8'h29);
        cs_high();
        compare_all("frame");

        // Unknown command with parameters, then a short RAMWR.
        cs_low();
        cmd(8'hB2);
        for (int i = 0; i < 5; i++) dat(8'($urandom));
        cmd(8'h2C); dat(8'hF8); dat(8'h00);
        compare_all("skip");

        // Reset in the middle of a pixel.
        cmd(8'h2C); dat(8'hAB);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_values("midrst");
        dat(8'h12); dat(8'h34);
        compare_all("midrst");
        cs_high();

        // Randomized command streams.
        for (int r = 0; r < 10; r++) begin
            cs_low();
            for (int a = 0; a < 6; a++) begin
                k = int'($urandom_range(4, 0));
                case (k)
                    0, 1: begin
                        s = int'($urandom_range(CMASK, 0));
                        e = int'($urandom_range(CMASK, s));
                        if (s > 40 && k == 0) s = e - int'($urandom_range(3, 0));
                        cmd(k == 0 ? 8'h2A : 8'h2B);
                        dat(8'((s >> 8) | int'($urandom_range(127, 0) << 1)));
                        dat(8'(s));
                        dat(8'(e >> 8));
                        dat(8'(e));
                        if ($urandom_range(1, 0) == 1) dat(8'($urandom));
                    end
                    2: begin
                        cmd(8'h2C);
                        for (int p = 0; p < int'($urandom_range(7, 1)); p++) begin
                            dat(8'($urandom)); dat(8'($urandom));
                        end
                        if ($urandom_range(1, 0) == 1) dat(8'($urandom));
                    end
                    3: begin
                        c = 8'($urandom_range(5, 0));
                        case (c)
                            8'd0: cmd(8'h10);
                            8'd1: cmd(8'h11);
                            8'd2: cmd(8'h20);
                            8'd3: cmd(8'h21);
                            8'd4: cmd(8'h28);
                            default: cmd(8'h29);
                        endcase
                    end
                    default: begin
                        c = 8'($urandom);
                        if (c == 8'h2A || c == 8'h2B) c = 8'hB2;
                        cmd(c);
                        for (int p = 0; p < int'($urandom_range(3, 0)); p++) dat(8'($urandom));
                    end
                endcase
                if ($urandom_range(3, 0) == 0) begin
                    cs_high();
                    cs_low();
                end
            end
            cs_high();
            compare_all($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
